line_fill_seq: RTL and testbench

LINE_FILL_SEQ -- requirements
Module: line_fill_seq

---
 rtl/line_fill_pkg.sv | 14 +
 rtl/fill_ret_pipe.sv | 38 +++
 rtl/line_fill_seq.sv | 117 +++++++++++
 tb/tb_line_fill_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_pkg.sv
// Shared state encoding and default geometry for the line-fill sequencer.
package line_fill_pkg;
  localparam int DEF_WORDS   = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    ABORT_DRAIN,
    DONE
  } fill_state_e;
endpackage

// File: rtl/fill_ret_pipe.sv
// Tracks outstanding reads: LATENCY-deep {valid, index} shift register.
module fill_ret_pipe #(
  parameter int LATENCY = 2,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  output logic             ret_vld,
  output logic [IDX_W-1:0] ret_idx,
  output logic             pending
);
  // Every stage except the output one: anything here still returns later.
  localparam logic [LATENCY-1:0] EARLY = {LATENCY{1'b1}} >> 1;

  logic [LATENCY-1:0]            vld_pipe;
  logic [LATENCY-1:0][IDX_W-1:0] idx_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= push && !flush;
      idx_pipe[0] <= push_idx;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] && !flush;
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign ret_vld = vld_pipe[LATENCY-1];
  assign ret_idx = idx_pipe[LATENCY-1];
  assign pending = |(vld_pipe & EARLY);
endmodule

// File: rtl/line_fill_seq.sv
// Cache line fill sequencer: issues WORDS reads (optionally critical-word-first)
// and marks each fixed-latency return for the line buffer.
module line_fill_seq
  import line_fill_pkg::*;
#(
  parameter  int WORDS   = DEF_WORDS,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int LATENCY = DEF_LATENCY,
  localparam int IDX_W   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic              cwf_en,
  input  logic              mem_stall,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_index,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_CNT = IDX_W'(WORDS - 1);

  fill_state_e       state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  off;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  cur_idx;
  logic              accept;
  logic              kill;
  logic              ret_vld;
  logic [IDX_W-1:0]  ret_idx;
  logic              ret_pending;

  // IDX_W-wide sum wraps the line index for free.
  assign cur_idx  = off + cnt;
  assign mem_rd   = (state == ISSUE) && !abort;
  assign mem_addr = base | {{(ADDR_W-IDX_W){1'b0}}, cur_idx};
  assign accept   = mem_rd && !mem_stall;
  assign kill     = abort && ((state == ISSUE) || (state == DRAIN));

  // A return landing in the abort cycle is dropped along with the flush.
  assign fill_we    = ret_vld && !kill;
  assign fill_index = ret_idx;

  fill_ret_pipe #(
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W)
  ) u_ret (
    .clk      (clk),
    .rst      (rst),
    .flush    (kill),
    .push     (accept),
    .push_idx (cur_idx),
    .ret_vld  (ret_vld),
    .ret_idx  (ret_idx),
    .pending  (ret_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      off   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= ISSUE;
            base  <= line_addr & ~IDX_MASK;
            off   <= cwf_en ? line_addr[IDX_W-1:0] : '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= ABORT_DRAIN;
          end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= ABORT_DRAIN;
          end else if (!ret_pending) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ABORT_DRAIN: begin
          if (!ret_pending) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_line_fill_seq.sv
// Directed bench for line_fill_seq with a queue-based model of fill behaviour.
module tb_line_fill_seq;
  localparam int WORDS   = 4;
  localparam int ADDR_W  = 16;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] line_addr = '0;
  logic        cwf_en = 1'b0;
  logic        mem_stall = 1'b0;
  logic        abort = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        fill_we;
  logic [1:0]  fill_index;
  logic        busy;
  logic        done;

  line_fill_seq #(.WORDS(WORDS), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .start(start), .line_addr(line_addr), .cwf_en(cwf_en),
    .mem_stall(mem_stall), .abort(abort), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .fill_we(fill_we), .fill_index(fill_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: fill phase plus a queue of returns keyed by the absolute cycle they land.
  typedef enum int {M_IDLE, M_ISSUE, M_DRAIN, M_ABORT, M_DONE} mph_e;
  mph_e        ph = M_IDLE;
  int          n_iss = 0;
  logic [15:0] m_base = '0;
  int          m_off = 0;
  int          rq_cyc[$];
  int          rq_idx[$];
  int          t = 0;

  // Per-scenario log of model expectations, indexed by cycle within scenario.
  int          sc;
  logic [31:0] l_rd, l_we, l_done, l_busy, l_addr_seq, l_idx_seq;
  logic [15:0] l_addr[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic new_sc();
    sc = 0;
    l_rd = '0; l_we = '0; l_done = '0; l_busy = '0; l_addr_seq = '0; l_idx_seq = '0;
    for (int i = 0; i < 32; i++) l_addr[i] = '0;
  endtask

  task automatic model_reset();
    ph = M_IDLE; n_iss = 0; m_base = '0; m_off = 0;
    rq_cyc.delete(); rq_idx.delete();
  endtask

  task automatic cyc(input logic s, input logic [15:0] a, input logic c,
                     input logic st, input logic ab);
    logic        ret_now, e_rd, e_we, e_busy, e_done;
    logic [15:0] e_addr;
    logic [1:0]  e_idx;
    @(posedge clk); #1;
    start = s; line_addr = a; cwf_en = c; mem_stall = st; abort = ab;
    #2;
    ret_now = (rq_cyc.size() > 0) && (rq_cyc[0] == t);
    e_rd    = (ph == M_ISSUE) && !ab;
    e_addr  = m_base | 16'((m_off + n_iss) % WORDS);
    e_we    = ret_now && !(ab && (ph == M_ISSUE || ph == M_DRAIN));
    e_idx   = ret_now ? 2'(rq_idx[0]) : 2'b00;
    e_busy  = (ph == M_ISSUE) || (ph == M_DRAIN) || (ph == M_ABORT);
    e_done  = (ph == M_DONE);

    chk("mem_rd", {31'b0, mem_rd}, {31'b0, e_rd});
    chk("fill_we", {31'b0, fill_we}, {31'b0, e_we});
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    chk("done", {31'b0, done}, {31'b0, e_done});
    if (ph == M_ISSUE) chk("mem_addr", {16'b0, mem_addr}, {16'b0, e_addr});
    if (e_we) chk("fill_index", {30'b0, fill_index}, {30'b0, e_idx});

    if (sc < 32) begin
      l_rd[sc] = e_rd; l_we[sc] = e_we; l_done[sc] = e_done; l_busy[sc] = e_busy;
      l_addr[sc] = e_addr;
    end
    if (e_rd && !st) l_addr_seq = {l_addr_seq[23:0], e_addr[7:0]};
    if (e_we) l_idx_seq = {l_idx_seq[27:0], 2'b00, e_idx};

    if (ret_now) begin
      void'(rq_cyc.pop_front());
      void'(rq_idx.pop_front());
    end
    case (ph)
      M_IDLE, M_DONE: begin
        if (s) begin
          ph = M_ISSUE; n_iss = 0;
          m_base = a & ~16'(WORDS - 1);
          m_off = c ? (int'(a) % WORDS) : 0;
        end else ph = M_IDLE;
      end
      M_ISSUE: begin
        if (ab) begin
          ph = M_ABORT; rq_cyc.delete(); rq_idx.delete();
        end else if (!st) begin
          rq_cyc.push_back(t + LATENCY);
          rq_idx.push_back((m_off + n_iss) % WORDS);
          n_iss++;
          if (n_iss == WORDS) ph = M_DRAIN;
        end
      end
      M_DRAIN: begin
        if (ab) begin
          ph = M_ABORT; rq_cyc.delete(); rq_idx.delete();
        end else if (rq_cyc.size() == 0) ph = M_DONE;
      end
      M_ABORT: if (rq_cyc.size() == 0) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
    t++; sc++;
  endtask

  task automatic run(input logic [15:0] a, input logic c, input logic [31:0] s_m,
                     input logic [31:0] st_m, input logic [31:0] ab_m, input int n);
    for (int i = 0; i < n; i++) cyc(s_m[i], a, c, st_m[i], ab_m[i]);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd"},   {31'b0, mem_rd}, 32'h0);
    chk({nm, "_addr"}, {16'b0, mem_addr}, 32'h0);
    chk({nm, "_we"},   {31'b0, fill_we}, 32'h0);
    chk({nm, "_idx"},  {30'b0, fill_index}, 32'h0);
    chk({nm, "_busy"}, {31'b0, busy}, 32'h0);
    chk({nm, "_done"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    #2 chk_zero("rst");
    #10 rst = 1'b0;

    // Linear fill
    new_sc(); run(16'h0128, 1'b0, 32'h1, 32'h0, 32'h0, 10);
    chk("s1_rd", l_rd, 32'h1E);
    chk("s1_we", l_we, 32'h78);
    chk("s1_done", l_done, 32'h80);
    chk("s1_addr", l_addr_seq, 32'h28292A2B);
    chk("s1_idx", l_idx_seq, 32'h0123);

    // Critical word first
    new_sc(); run(16'h012A, 1'b1, 32'h1, 32'h0, 32'h0, 10);
    chk("s2_addr", l_addr_seq, 32'h2A2B2829);
    chk("s2_idx", l_idx_seq, 32'h2301);
    chk("s2_done", l_done, 32'h80);

    // Stall in cycle 2
    new_sc(); run(16'h0128, 1'b0, 32'h1, 32'h4, 32'h0, 11);
    chk("s3_rd", l_rd, 32'h3E);
    chk("s3_we", l_we, 32'hE8);
    chk("s3_done", l_done, 32'h100);
    chk("s3_hold", {l_addr[2], l_addr[3]}, 32'h01290129);

    // Abort during issue, then abort while idle (ignored)
    new_sc(); run(16'h0128, 1'b0, 32'h1, 32'h0, 32'h4, 8);
    chk("s4_rd", l_rd, 32'h02);
    chk("s4_we", l_we, 32'h0);
    chk("s4_busy", l_busy, 32'h0E);
    chk("s4_done", l_done, 32'h0);
    new_sc(); run(16'h0000, 1'b0, 32'h0, 32'h0, 32'h7, 3);

    // Abort during drain
    new_sc(); run(16'h0128, 1'b0, 32'h1, 32'h0, 32'h20, 10);
    chk("s5_we", l_we, 32'h18);
    chk("s5_busy", l_busy, 32'h7E);
    chk("s5_done", l_done, 32'h0);

    // Reset mid-fill in cycle 3
    new_sc(); run(16'h0128, 1'b0, 32'h1, 32'h0, 32'h0, 3);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; mem_stall = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero("mid_rst");
    model_reset(); t++;
    #1 rst = 1'b0;
    new_sc(); run(16'h0000, 1'b0, 32'h0, 32'h0, 32'h0, 6);
    chk("s6_quiet_we", l_we, 32'h0);
    chk("s6_quiet_done", l_done, 32'h0);
    new_sc(); run(16'h0128, 1'b0, 32'h1, 32'h0, 32'h0, 10);
    chk("s6_we", l_we, 32'h78);
    chk("s6_idx", l_idx_seq, 32'h0123);
    chk("s6_done", l_done, 32'h80);

    // Start held through cycles 0-7: restart straight from DONE
    new_sc(); run(16'h0128, 1'b0, 32'hFF, 32'h0, 32'h0, 17);
    chk("s7_rd", l_rd, 32'h0F1E);
    chk("s7_we", l_we, 32'h3C78);
    chk("s7_done", l_done, 32'h4080);

    // Top-of-space wrap with critical word at index 3
    new_sc(); run(16'hFFFF, 1'b1, 32'h1, 32'h0, 32'h0, 10);
    chk("s8_addr", l_addr_seq, 32'hFFFCFDFE);
    chk("s8_idx", l_idx_seq, 32'h3012);
    chk("s8_first", {16'b0, l_addr[1]}, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
